// File: rtl/draw_sprite_array_if.sv
// VGA stream interface: pixel counters, sync, blanking and 12-bit RGB.
// Modport "in" is the consumer side of a stream and "out" the producer
// side; "slave"/"master" name the same roles for generic wiring.
interface vga_if;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport in     (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport out    (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_sprite_array.sv
// Sprite overlay stage: draws N_SPRITES animated, colour-keyed sprites on
// top of the incoming VGA stream with fixed index priority (slot 0 on top).
// Positions are written into shadow registers and become visible together
// at the next vblnk rising edge, so a frame is never drawn half-updated.
// Latency is two clocks for every output field.
// Optional feature macro: SPRITE_MIRROR_EN (per-slot horizontal mirror).
module draw_sprite_array #(
   parameter int          N_SPRITES    = 4,
   parameter int          SPR_W_LOG2   = 6,
   parameter int          SPR_H_LOG2   = 6,
   parameter int          N_FRAMES     = 2,
   parameter int          FRAME_PERIOD = 8,
   parameter logic [11:0] TRANSPARENT  = 12'hF0F,
   localparam int         FB = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
   localparam int         AW = FB + SPR_H_LOG2 + SPR_W_LOG2,
   localparam int         IW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
   input  logic                   clk60MHz,
   input  logic                   rst,
   input  logic                   pos_wr,
   output logic                   pos_ready,
   input  logic [IW-1:0]          pos_idx,
   input  logic [10:0]            pos_x,
   input  logic [10:0]            pos_y,
   input  logic                   pos_en,
   input  logic                   pos_mirror,
   output logic [N_SPRITES*AW-1:0] pixel_addr,
   input  logic [N_SPRITES*12-1:0] rgb_pixel,
   vga_if.in                      in,
   vga_if.out                     out
);
   localparam int          FCW   = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
   localparam logic [11:0] SPR_W = 12'(1 << SPR_W_LOG2);
   localparam logic [11:0] SPR_H = 12'(1 << SPR_H_LOG2);

   logic                 vblnk_prev_reg;
   logic                 commit;
   logic                 wr_accept;
   logic [FB-1:0]        anim_frame_reg;
   logic [FCW-1:0]       frame_cnt_reg;
   logic [11:0]          hc12;
   logic [11:0]          vc12;
   logic [N_SPRITES-1:0] hit_s1;

   logic [10:0] s1_hcount_reg, s1_vcount_reg;
   logic        s1_hsync_reg, s1_vsync_reg, s1_hblnk_reg, s1_vblnk_reg;
   logic [11:0] s1_rgb_reg;
   logic [11:0] sel_rgb;

   // Commit strobe is the first cycle of vblnk; writes are held off then so
   // a shadow update can never race the shadow-to-active copy.
   assign commit    = !rst && in.vblnk && !vblnk_prev_reg;
   assign pos_ready = !commit;
   assign wr_accept = pos_wr && pos_ready;

   // Widen counters to 12 bits so x + sprite width near 2047 cannot wrap.
   assign hc12 = {1'b0, in.hcount};
   assign vc12 = {1'b0, in.vcount};

`ifndef SPRITE_MIRROR_EN
   logic unused_mirror;
   assign unused_mirror = pos_mirror;
`endif

   // Track previous vblnk for the rising-edge detect.
   always_ff @(posedge clk60MHz) begin
      if (rst) vblnk_prev_reg <= 1'b0;
      else     vblnk_prev_reg <= in.vblnk;
   end

   // Animation step counter: advances the frame index on the commit edge.
   always_ff @(posedge clk60MHz) begin
      if (rst) begin
         frame_cnt_reg  <= '0;
         anim_frame_reg <= '0;
      end else if (commit) begin
         if (frame_cnt_reg == FCW'(FRAME_PERIOD - 1)) begin
            frame_cnt_reg <= '0;
            if (N_FRAMES > 1) anim_frame_reg <= anim_frame_reg + FB'(1);
         end else begin
            frame_cnt_reg <= frame_cnt_reg + FCW'(1);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_SPRITES; gi++) begin : g_slot
         logic [10:0]           sh_x_reg, sh_y_reg, act_x_reg, act_y_reg;
         logic                  sh_en_reg, act_en_reg;
         logic [11:0]           x12, y12;
         logic [SPR_W_LOG2-1:0] dx, dx_field;
         logic [SPR_H_LOG2-1:0] dy;
         logic                  in_x, in_y, hit_s0, hit_s1_reg, wr_sel;

         assign wr_sel = wr_accept && (pos_idx == IW'(gi));

         // Shadow takes accepted writes; active follows shadow on commit.
         always_ff @(posedge clk60MHz) begin
            if (rst) begin
               sh_x_reg   <= '0;
               sh_y_reg   <= '0;
               sh_en_reg  <= 1'b0;
               act_x_reg  <= '0;
               act_y_reg  <= '0;
               act_en_reg <= 1'b0;
            end else begin
               if (wr_sel) begin
                  sh_x_reg  <= pos_x;
                  sh_y_reg  <= pos_y;
                  sh_en_reg <= pos_en;
               end
               if (commit) begin
                  act_x_reg  <= sh_x_reg;
                  act_y_reg  <= sh_y_reg;
                  act_en_reg <= sh_en_reg;
               end
            end
         end

         // Only the low bits of the offset feed the ROM address.
         assign dx = in.hcount[SPR_W_LOG2-1:0] - act_x_reg[SPR_W_LOG2-1:0];
         assign dy = in.vcount[SPR_H_LOG2-1:0] - act_y_reg[SPR_H_LOG2-1:0];

`ifdef SPRITE_MIRROR_EN
         logic sh_mirror_reg, act_mirror_reg;

         // Mirror flag rides the same shadow/commit path as the position.
         always_ff @(posedge clk60MHz) begin
            if (rst) begin
               sh_mirror_reg  <= 1'b0;
               act_mirror_reg <= 1'b0;
            end else begin
               if (wr_sel) sh_mirror_reg  <= pos_mirror;
               if (commit) act_mirror_reg <= sh_mirror_reg;
            end
         end

         assign dx_field = act_mirror_reg ? ~dx : dx;
`else
         assign dx_field = dx;
`endif

         assign pixel_addr[gi*AW +: AW] = rst ? '0 : {anim_frame_reg, dy, dx_field};

         assign x12    = {1'b0, act_x_reg};
         assign y12    = {1'b0, act_y_reg};
         assign in_x   = (hc12 >= x12) && (hc12 < x12 + SPR_W);
         assign in_y   = (vc12 >= y12) && (vc12 < y12 + SPR_H);
         assign hit_s0 = act_en_reg && in_x && in_y && !in.hblnk && !in.vblnk;

         // Hit flag travels alongside the ROM read so both arrive at stage 1.
         always_ff @(posedge clk60MHz) begin
            if (rst) hit_s1_reg <= 1'b0;
            else     hit_s1_reg <= hit_s0;
         end

         assign hit_s1[gi] = hit_s1_reg;
      end
   endgenerate

   // Stage 1: delay timing and background colour to meet the ROM data.
   always_ff @(posedge clk60MHz) begin
      if (rst) begin
         s1_hcount_reg <= '0;
         s1_vcount_reg <= '0;
         s1_hsync_reg  <= 1'b0;
         s1_vsync_reg  <= 1'b0;
         s1_hblnk_reg  <= 1'b0;
         s1_vblnk_reg  <= 1'b0;
         s1_rgb_reg    <= '0;
      end else begin
         s1_hcount_reg <= in.hcount;
         s1_vcount_reg <= in.vcount;
         s1_hsync_reg  <= in.hsync;
         s1_vsync_reg  <= in.vsync;
         s1_hblnk_reg  <= in.hblnk;
         s1_vblnk_reg  <= in.vblnk;
         s1_rgb_reg    <= in.rgb;
      end
   end

   // Lowest-index opaque hit wins; scanning downward lets slot 0 override.
   always_comb begin
      sel_rgb = s1_rgb_reg;
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
         if (hit_s1[i] && (rgb_pixel[i*12 +: 12] != TRANSPARENT))
            sel_rgb = rgb_pixel[i*12 +: 12];
      end
   end

   // Stage 2: registered outputs.
   always_ff @(posedge clk60MHz) begin
      if (rst) begin
         out.hcount <= '0;
         out.vcount <= '0;
         out.hsync  <= 1'b0;
         out.vsync  <= 1'b0;
         out.hblnk  <= 1'b0;
         out.vblnk  <= 1'b0;
         out.rgb    <= '0;
      end else begin
         out.hcount <= s1_hcount_reg;
         out.vcount <= s1_vcount_reg;
         out.hsync  <= s1_hsync_reg;
         out.vsync  <= s1_vsync_reg;
         out.hblnk  <= s1_hblnk_reg;
         out.vblnk  <= s1_vblnk_reg;
         out.rgb    <= sel_rgb;
      end
   end
endmodule

// File: tb/tb_draw_sprite_array.sv
// Bench for draw_sprite_array: compact directed pixel stream (counters jump
// straight to the pixels of interest), scoreboard queue checked by a monitor.
module tb_draw_sprite_array;
   localparam int N  = 4;
   localparam int AW = 13;

   logic            clk60MHz = 1'b0;
   logic            rst = 1'b1;
   logic            pos_wr = 1'b0;
   logic            pos_ready;
   logic [1:0]      pos_idx = '0;
   logic [10:0]     pos_x = '0;
   logic [10:0]     pos_y = '0;
   logic            pos_en = 1'b0;
   logic            pos_mirror = 1'b0;
   logic [N*AW-1:0] pixel_addr;
   logic [N*12-1:0] rgb_pixel = '0;

   vga_if vin ();
   vga_if vout ();

   always #5 clk60MHz = ~clk60MHz;

   draw_sprite_array dut (
      .clk60MHz  (clk60MHz),
      .rst       (rst),
      .pos_wr    (pos_wr),
      .pos_ready (pos_ready),
      .pos_idx   (pos_idx),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .pos_en    (pos_en),
      .pos_mirror(pos_mirror),
      .pixel_addr(pixel_addr),
      .rgb_pixel (rgb_pixel),
      .in        (vin),
      .out       (vout)
   );

   // Sprite ROMs: slot s returns {s+1, frame, dy[0], dx}; slot 0 is
   // transparent at dy=0, dx=5.
   function automatic logic [11:0] rom_val(int s, logic [AW-1:0] a);
      if (s == 0 && a[11:0] == 12'h005) return 12'hF0F;
      return {4'(s + 1), a[12], a[6:0]};
   endfunction

   always @(posedge clk60MHz)
      for (int s = 0; s < N; s++)
         rgb_pixel[s*12 +: 12] <= rom_val(s, pixel_addr[s*AW +: AW]);

   typedef struct {
      int          due;
      int          id;
      logic [10:0] h, v;
      logic        hs, vs, hb, vb;
      logic [11:0] rgb;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   chk_slot = -1;
   logic [AW-1:0] chk_addr;
   int   exp_ready = -1;
   int   rises = 0;

   always @(posedge clk60MHz) cyc <= cyc + 1;

   // Monitor: pops each expected output when its cycle comes due.
   always @(negedge clk60MHz) begin
      exp_t e;
      while (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         total++;
         if (e.due != cyc || vout.hcount !== e.h || vout.vcount !== e.v ||
             vout.hsync !== e.hs || vout.vsync !== e.vs ||
             vout.hblnk !== e.hb || vout.vblnk !== e.vb || vout.rgb !== e.rgb) begin
            bad++;
            $display("FAIL px%0d: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h",
                     e.id, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk,
                     vout.vblnk, vout.rgb, e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb);
         end else begin
            $display("ok px%0d h=%0d v=%0d rgb=%h", e.id, e.h, e.v, e.rgb);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end else begin
         $display("ok %s: %0h", name, got);
      end
   endtask

   // One pixel per clock, driven just after a falling edge.
   task automatic step(input int id, input logic [10:0] h, input logic [10:0] v,
                       input logic hb, input logic vb,
                       input logic [11:0] rgb, input logic [11:0] exp_rgb);
      exp_t e;
      vin.hcount = h;  vin.vcount = v;
      vin.hsync  = h[4]; vin.vsync = v[1];
      vin.hblnk  = hb; vin.vblnk  = vb; vin.rgb = rgb;
      e.due = cyc + 2; e.id = id; e.h = h; e.v = v;
      e.hs = h[4]; e.vs = v[1]; e.hb = hb; e.vb = vb; e.rgb = exp_rgb;
      q.push_back(e);
      #1;
      if (chk_slot >= 0) begin
         check($sformatf("addr%0d px%0d", chk_slot, id),
               64'(pixel_addr[chk_slot*AW +: AW]), 64'(chk_addr));
         chk_slot = -1;
      end
      if (exp_ready >= 0) begin
         check($sformatf("ready px%0d", id), 64'(pos_ready), 64'(exp_ready));
         exp_ready = -1;
      end
      @(negedge clk60MHz);
   endtask

   // Two vblank cycles: commit cycle (ready low) then the following cycle.
   task automatic vblank(input int id);
      exp_ready = 0;
      step(id, 11'd0, 11'd600, 1'b1, 1'b1, 12'h0A0, 12'h0A0);
      exp_ready = 1;
      step(id + 1, 11'd0, 11'd601, 1'b1, 1'b1, 12'h0A0, 12'h0A0);
      rises++;
   endtask

   task automatic wr(input int id, input logic [1:0] idx, input logic [10:0] x,
                     input logic [10:0] y, input logic en, input logic mir);
      pos_idx = idx; pos_x = x; pos_y = y; pos_en = en; pos_mirror = mir;
      pos_wr = 1'b1;
      step(id, 11'd700, 11'd590, 1'b0, 1'b0, 12'h0AA, 12'h0AA);
      pos_wr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] fr;
      vin.hcount = 11'd123; vin.vcount = 11'd45; vin.hsync = 1'b1; vin.vsync = 1'b1;
      vin.hblnk = 1'b1; vin.vblnk = 1'b0; vin.rgb = 12'hABC;
      repeat (3) @(negedge clk60MHz);
      check("rst out.rgb", 64'(vout.rgb), 64'h0);
      check("rst out.hcount", 64'(vout.hcount), 64'h0);
      check("rst out.hsync", 64'(vout.hsync), 64'h0);
      check("rst pos_ready", 64'(pos_ready), 64'h1);
      check("rst pixel_addr", 64'(pixel_addr), 64'h0);
      rst = 1'b0;

      // All slots disabled: pure passthrough.
      for (int k = 0; k < 10; k++)
         step(k, 11'(k * 70), 11'(k + 3), (k == 9), 1'b0,
              12'(12'h100 + k * 17), 12'(12'h100 + k * 17));
      vblank(20);

      // Slot 0 at (100,200) written mid-frame: invisible until commit.
      wr(30, 2'd0, 11'd100, 11'd200, 1'b1, 1'b0);
      step(31, 11'd100, 11'd200, 1'b0, 1'b0, 12'h777, 12'h777);
      vblank(32);
      chk_slot = 0; chk_addr = '0;
      step(40, 11'd100, 11'd200, 1'b0, 1'b0, 12'h777, 12'h100);
      step(41, 11'd101, 11'd201, 1'b0, 1'b0, 12'h777, 12'h141);
      step(42, 11'd163, 11'd263, 1'b0, 1'b0, 12'h777, 12'h17F);
      step(43, 11'd164, 11'd200, 1'b0, 1'b0, 12'h777, 12'h777);
      step(44, 11'd99,  11'd200, 1'b0, 1'b0, 12'h777, 12'h777);
      step(45, 11'd100, 11'd264, 1'b0, 1'b0, 12'h777, 12'h777);
      step(46, 11'd100, 11'd200, 1'b1, 1'b0, 12'h777, 12'h777);

      // Slots 0 and 1 overlapping at (300,300).
      wr(50, 2'd0, 11'd300, 11'd300, 1'b1, 1'b0);
      wr(51, 2'd1, 11'd300, 11'd300, 1'b1, 1'b0);
      vblank(52);
      chk_slot = 0; chk_addr = 13'h0005;
      step(60, 11'd305, 11'd300, 1'b0, 1'b0, 12'h555, 12'h205);
      step(61, 11'd306, 11'd300, 1'b0, 1'b0, 12'h555, 12'h106);
      step(62, 11'd305, 11'd301, 1'b0, 1'b0, 12'h555, 12'h145);
      step(63, 11'd360, 11'd300, 1'b0, 1'b0, 12'h555, 12'h13C);

      // Slot 2 at right edge: no wrap into hcount 0..55.
      wr(70, 2'd2, 11'd2040, 11'd0, 1'b1, 1'b0);
      vblank(71);
      step(80, 11'd2040, 11'd0, 1'b0, 1'b0, 12'h333, 12'h300);
      step(81, 11'd2047, 11'd5, 1'b0, 1'b0, 12'h333, 12'h347);
      step(82, 11'd0,    11'd0, 1'b0, 1'b0, 12'h333, 12'h333);
      step(83, 11'd55,   11'd1, 1'b0, 1'b0, 12'h333, 12'h333);

      // Animation: frame bit flips at rises 8 and 16.
      for (int r = 5; r <= 16; r++) begin
         vblank(100 + r * 4);
         fr = AW'((r / 8) % 2);
         chk_slot = 2; chk_addr = fr << 12;
         step(102 + r * 4, 11'd2040, 11'd0, 1'b0, 1'b0, 12'h333,
              12'h300 | (12'(fr) << 7));
      end

      // Write held high across a commit: ready low one cycle, lands next.
      pos_idx = 2'd3; pos_x = 11'd500; pos_y = 11'd400; pos_en = 1'b1; pos_mirror = 1'b0;
      pos_wr = 1'b1;
      vblank(200);
      pos_wr = 1'b0;
      step(202, 11'd500, 11'd400, 1'b0, 1'b0, 12'h0CC, 12'h0CC);
      vblank(203);
      chk_slot = 3; chk_addr = '0;
      step(205, 11'd500, 11'd400, 1'b0, 1'b0, 12'h0CC, 12'h400);
      step(206, 11'd563, 11'd463, 1'b0, 1'b0, 12'h0CC, 12'h47F);

`ifdef SPRITE_MIRROR_EN
      wr(210, 2'd3, 11'd500, 11'd400, 1'b1, 1'b1);
      vblank(211);
      chk_slot = 3; chk_addr = 13'd63;
      step(213, 11'd500, 11'd400, 1'b0, 1'b0, 12'h0CC, 12'h43F);
`endif

      step(220, 11'd700, 11'd590, 1'b0, 1'b0, 12'h0AA, 12'h0AA);
      repeat (4) @(negedge clk60MHz);
      check("queue drained", 64'(q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
